// File: rtl/cam_pkg.sv
// Shared types and sizing for the CAM match resolver: state encoding,
// output beat layout and default geometry.
package cam_pkg;

  localparam int CAM_ENTRIES = 16;
  localparam int CAM_ADDR_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    MISS = 2'd2
  } cam_res_state_t;

  typedef struct packed {
    logic [CAM_ADDR_W-1:0] addr;
    logic                  miss;
    logic                  last;
  } cam_res_beat_t;

endpackage

// File: rtl/cam_match_resolver_if.sv
// Match-vector input channel and encoded-address output channel of the resolver.
// master = CAM/consumer side, slave = resolver side.
interface cam_match_resolver_if
  import cam_pkg::*;
#(
  parameter int ENTRIES = CAM_ENTRIES,
  parameter int ADDR_W  = CAM_ADDR_W
);

  logic               match_valid;
  logic               match_ready;
  logic [ENTRIES-1:0] match_vec;
  logic               out_valid;
  logic               out_ready;
  logic [ADDR_W-1:0]  out_addr;
  logic               out_miss;
  logic               out_last;
  logic [ADDR_W:0]    hit_count;

  modport master (
    output match_valid, match_vec, out_ready,
    input  match_ready, out_valid, out_addr, out_miss, out_last, hit_count
  );

  modport slave (
    input  match_valid, match_vec, out_ready,
    output match_ready, out_valid, out_addr, out_miss, out_last, hit_count
  );

endinterface

// File: rtl/cam_prio_enc.sv
// Lowest-set-bit priority encoder with any-set and exactly-one-set flags.
module cam_prio_enc #(
  parameter int ENTRIES = 16,
  parameter int ADDR_W  = 4
) (
  input  logic [ENTRIES-1:0] vec,
  output logic [ADDR_W-1:0]  idx,
  output logic               any,
  output logic               one
);

  // NOTE: idx gets a default before the loop so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (vec[i]) idx = ADDR_W'(i);
    end
  end

  assign any = |vec;
  // Clearing the lowest set bit leaves zero only for a one-hot vector.
  assign one = any && ((vec & (vec - ENTRIES'(1))) == '0);

endmodule

// File: rtl/cam_match_resolver.sv
// Drains a captured CAM match vector as encoded addresses, lowest first;
// an empty vector yields one miss beat. Define CAM_RESOLVER_HIT_COUNT_EN for hit_count.
module cam_match_resolver
  import cam_pkg::*;
#(
  parameter int ENTRIES = CAM_ENTRIES,
  parameter int ADDR_W  = CAM_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  cam_match_resolver_if.slave  bus
);

  localparam int CNT_W = ADDR_W + 1;

  cam_res_state_t     state_q, state_d;
  logic [ENTRIES-1:0] pend_q, pend_d;
  cam_res_beat_t      beat;
  logic [ADDR_W-1:0]  enc_idx;
  logic               enc_any;
  logic               enc_one;
  logic               accept;

  cam_prio_enc #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W)) u_enc (
    .vec (pend_q),
    .idx (enc_idx),
    .any (enc_any),
    .one (enc_one)
  );

  assign accept = (state_q == IDLE) && bus.match_valid;

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    pend_d          = pend_q;
    beat            = '0;
    bus.match_ready = 1'b0;
    bus.out_valid   = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.match_ready = 1'b1;
        if (accept) begin
          pend_d  = bus.match_vec;
          state_d = (|bus.match_vec) ? EMIT : MISS;
        end
      end
      EMIT: begin
        bus.out_valid = 1'b1;
        beat.addr     = enc_idx;
        beat.last     = enc_one;
        if (bus.out_ready) begin
          pend_d = pend_q & ~(ENTRIES'(1) << enc_idx);
          if (enc_one || !enc_any) state_d = IDLE;
        end
      end
      MISS: begin
        bus.out_valid = 1'b1;
        beat.miss     = 1'b1;
        beat.last     = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.out_addr = beat.addr;
  assign bus.out_miss = beat.miss;
  assign bus.out_last = beat.last;

`ifdef CAM_RESOLVER_HIT_COUNT_EN
  logic [CNT_W-1:0] hit_q, hit_d;

  always_comb begin
    hit_d = hit_q;
    if (accept) begin
      hit_d = '0;
      for (int i = 0; i < ENTRIES; i++) hit_d = hit_d + CNT_W'(bus.match_vec[i]);
    end else if (state_d == IDLE) begin
      hit_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hit_q <= '0;
    else     hit_q <= hit_d;
  end

  assign bus.hit_count = hit_q;
`else
  assign bus.hit_count = CNT_W'(0);
`endif

endmodule

// File: tb/tb_cam_match_resolver.sv
// Self-checking bench for cam_match_resolver: queue-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_cam_match_resolver;

`ifdef CAM_RESOLVER_HIT_COUNT_EN
  localparam bit HC_EN = 1'b1;
`else
  localparam bit HC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  cam_match_resolver_if #(.ENTRIES(16), .ADDR_W(4)) bus ();

  cam_match_resolver dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the pending lookup is a queue of addresses still to be
  // emitted (-1 stands for the miss beat). Evaluated at negedge, when inputs
  // for the coming rising edge are already stable.
  int q[$];
  int exp_hc = 0;
  bit exp_valid;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      exp_hc = 0;
    end
    exp_valid = (q.size() != 0);
    check("out_valid", bus.out_valid, exp_valid);
    check("match_ready", bus.match_ready, !exp_valid);
    check("hit_count", bus.hit_count, exp_hc);
    if (exp_valid) begin
      check("out_addr", bus.out_addr, (q[0] < 0) ? 0 : q[0]);
      check("out_miss", bus.out_miss, q[0] < 0);
      check("out_last", bus.out_last, q.size() == 1);
    end
    if (!rst) begin
      if (exp_valid && bus.out_ready) begin
        void'(q.pop_front());
        if (q.size() == 0) exp_hc = 0;
      end else if (!exp_valid && bus.match_valid) begin
        for (int i = 0; i < 16; i++) if (bus.match_vec[i]) q.push_back(i);
        if (q.size() == 0) q.push_back(-1);
        exp_hc = HC_EN ? $countones(bus.match_vec) : 0;
      end
    end
  end

  // Present a vector from posedge+1 until accepted; returns at posedge+1 after
  // the accepting edge.
  task automatic send(input logic [15:0] v);
    bit got = 0;
    bus.match_valid = 1'b1;
    bus.match_vec   = v;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (bus.match_ready) begin
        got = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check("accept_timeout", got, 1);
    @(posedge clk); #1;
    bus.match_valid = 1'b0;
    bus.match_vec   = 16'($urandom);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  int exp_multi[4] = '{0, 5, 10, 15};

  initial begin
    int beats, last_addr;
    bit ordered, done;
    logic [15:0] v;

    bus.match_valid = 1'b0;
    bus.match_vec   = '0;
    bus.out_ready   = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_match_ready", bus.match_ready, 1);
    check("rst_out_addr", bus.out_addr, 0);
    check("rst_out_last", bus.out_last, 0);
    step(); step();
    rst = 1'b0;

    // Single hit
    send(16'h0010);
    @(negedge clk);
    check("single_valid", bus.out_valid, 1);
    check("single_addr", bus.out_addr, 4);
    check("single_last", bus.out_last, 1);
    check("single_miss", bus.out_miss, 0);
    check("single_ready_low", bus.match_ready, 0);
    step();
    @(negedge clk);
    check("single_ready_back", bus.match_ready, 1);
    check("single_done", bus.out_valid, 0);
    step();

    // Multi-hit
    send(16'h8421);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("multi_addr", bus.out_addr, exp_multi[i]);
      check("multi_last", bus.out_last, i == 3);
      check("multi_hc", bus.hit_count, HC_EN ? 4 : 0);
      step();
    end

    // Miss, followed immediately by a new lookup
    send(16'h0000);
    @(negedge clk);
    check("miss_miss", bus.out_miss, 1);
    check("miss_last", bus.out_last, 1);
    check("miss_addr", bus.out_addr, 0);
    step();
    send(16'h0001);
    @(negedge clk);
    check("post_miss_addr", bus.out_addr, 0);
    check("post_miss_valid", bus.out_valid, 1);
    step();

    // Backpressure with ignored match_valid pulses
    bus.out_ready = 1'b0;
    send(16'h0006);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_hold_addr", bus.out_addr, 1);
      check("bp_hold_last", bus.out_last, 0);
      step();
      bus.match_valid = 1'b1;
      bus.match_vec   = 16'($urandom);
    end
    bus.match_valid = 1'b0;
    bus.out_ready   = 1'b1;
    @(negedge clk);
    check("bp_release_addr", bus.out_addr, 1);
    step();
    @(negedge clk);
    check("bp_second_addr", bus.out_addr, 2);
    check("bp_second_last", bus.out_last, 1);
    step();

    // Full vector with random backpressure
    bus.out_ready = 1'($urandom_range(0, 1));
    send(16'hFFFF);
    beats = 0; last_addr = -1; ordered = 1; done = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        if (int'(bus.out_addr) != beats) ordered = 0;
        beats++;
        last_addr = int'(bus.out_addr);
        if (bus.out_last) done = 1;
      end
      if (done) break;
      step();
      bus.out_ready = 1'($urandom_range(0, 1));
    end
    check("full_beats", beats, 16);
    check("full_order", ordered, 1);
    check("full_last_addr", last_addr, 15);
    step();
    bus.out_ready = 1'b1;
    step();

    // Reset mid-stream
    send(16'h00F0);
    @(negedge clk);
    check("rstmid_first", bus.out_addr, 4);
    step();
    rst = 1'b1;
    #1;
    check("rstmid_valid_now", bus.out_valid, 0);
    check("rstmid_addr_now", bus.out_addr, 0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rstmid_ready", bus.match_ready, 1);
      check("rstmid_no_beat", bus.out_valid, 0);
      step();
    end

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      step();
      bus.match_valid = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       v = '0;
        1:       v = 16'(1) << $urandom_range(0, 15);
        2:       v = 16'($urandom & $urandom);
        default: v = 16'($urandom);
      endcase
      bus.match_vec = v;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rst           = ($urandom_range(0, 149) == 0);
    end
    step();
    rst = 1'b0;
    bus.match_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule
